// File: rtl/decode_issue_queue.sv
// Decode/issue stage: a DEPTH-entry instruction FIFO whose head is decoded and
// has its operands resolved each cycle. It issues through a registered
// one-cycle pulse and is flushed on rollback.
module decode_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned N_CDB     = 2,
  parameter int unsigned ROB_POS_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy_i,
  input  logic                       rollback_i,
  input  logic                       inst_done_i,
  input  logic [31:0]                inst_i,
  input  logic [31:0]                inst_pc_i,
  input  logic                       inst_pre_j_i,
  output logic                       queue_full_o,
  input  logic                       rob_full_i,
  input  logic                       rs_full_i,
  input  logic                       lsb_full_i,
  input  logic [ROB_POS_W-1:0]       upd_rob_pos_i,
  output logic [4:0]                 reg_rs1_o,
  output logic [4:0]                 reg_rs2_o,
  input  logic                       reg_rs1_rdy_i,
  input  logic [31:0]                reg_rs1_val_i,
  input  logic [ROB_POS_W-1:0]       reg_rs1_rob_pos_i,
  input  logic                       reg_rs2_rdy_i,
  input  logic [31:0]                reg_rs2_val_i,
  input  logic [ROB_POS_W-1:0]       reg_rs2_rob_pos_i,
  output logic [ROB_POS_W-1:0]       rob_rs1_pos_o,
  output logic [ROB_POS_W-1:0]       rob_rs2_pos_o,
  input  logic                       rob_rs1_rdy_i,
  input  logic [31:0]                rob_rs1_val_i,
  input  logic                       rob_rs2_rdy_i,
  input  logic [31:0]                rob_rs2_val_i,
  input  logic [N_CDB-1:0]           cdb_valid_i,
  input  logic [N_CDB*ROB_POS_W-1:0] cdb_rob_pos_i,
  input  logic [N_CDB*32-1:0]        cdb_val_i,
  output logic                       issue_o,
  output logic                       rs_en_o,
  output logic                       lsb_en_o,
  output logic                       is_store_o,
  output logic [ROB_POS_W-1:0]       rob_pos_o,
  output logic [6:0]                 opcode_o,
  output logic [2:0]                 funct3_o,
  output logic                       funct7_o,
  output logic [4:0]                 rd_o,
  output logic [31:0]                imm_o,
  output logic [31:0]                pc_o,
  output logic                       pre_j_o,
  output logic                       rs1_rdy_o,
  output logic [31:0]                rs1_val_o,
  output logic [ROB_POS_W-1:0]       rs1_rob_pos_o,
  output logic                       rs2_rdy_o,
  output logic [31:0]                rs2_val_o,
  output logic [ROB_POS_W-1:0]       rs2_rob_pos_o,
  output logic                       illegal_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OpL     = 7'b0000011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpCal   = 7'b0110011;
  localparam logic [6:0] OpCali  = 7'b0010011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;

  typedef struct packed {
    logic                 pre_j;
    logic [31:0]          pc;
    logic [31:0]          inst;
  } entry_t;

  typedef struct packed {
    logic                 rdy;
    logic [31:0]          val;
    logic [ROB_POS_W-1:0] pos;
  } opnd_t;

  typedef struct packed {
    logic                 rs_en;
    logic                 lsb_en;
    logic                 is_store;
    logic [ROB_POS_W-1:0] rob_pos;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic                 pre_j;
    opnd_t                rs1;
    opnd_t                rs2;
  } issue_t;

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  issue_t            data_q, data_d;
  logic              issue_q, illegal_q;

  entry_t            head;
  logic [6:0]        op;
  logic              known, full, target_full, active, fire, drop, push, pop;

  // Unused or x0 sources read as ready zero; otherwise RegFile, then the
  // lowest-index matching CDB channel, then RoB, else wait on the tag.
  function automatic opnd_t resolve(input logic                       used,
                                    input logic [4:0]                 src,
                                    input logic                       reg_rdy,
                                    input logic [31:0]                reg_val,
                                    input logic [ROB_POS_W-1:0]       tag,
                                    input logic                       rob_rdy,
                                    input logic [31:0]                rob_val,
                                    input logic [N_CDB-1:0]           cv,
                                    input logic [N_CDB*ROB_POS_W-1:0] ctag,
                                    input logic [N_CDB*32-1:0]        cval);
    opnd_t o;
    logic  hit;
    o.rdy = 1'b1;
    o.val = '0;
    o.pos = '0;
    hit   = 1'b0;
    if (used && src != 5'd0) begin
      if (reg_rdy) begin
        o.val = reg_val;
      end else begin
        // Descending scan so the lowest matching channel is written last.
        for (int i = int'(N_CDB) - 1; i >= 0; i--) begin
          if (cv[i] && ctag[i*ROB_POS_W +: ROB_POS_W] == tag) begin
            hit   = 1'b1;
            o.val = cval[i*32 +: 32];
          end
        end
        if (!hit) begin
          if (rob_rdy) begin
            o.val = rob_val;
          end else begin
            o.rdy = 1'b0;
            o.pos = tag;
          end
        end
      end
    end
    return o;
  endfunction

  // Combinational decode of the head entry.
  always_comb begin
    head  = mem_q[head_q];
    op    = head.inst[6:0];
    known = op inside {OpL, OpS, OpCal, OpCali, OpB, OpLui, OpAuipc, OpJal, OpJalr};

    data_d          = '0;
    data_d.opcode   = op;
    data_d.funct3   = head.inst[14:12];
    data_d.funct7   = head.inst[30];
    data_d.rd       = (op == OpS || op == OpB) ? 5'd0 : head.inst[11:7];
    data_d.pc       = head.pc;
    data_d.pre_j    = head.pre_j;
    data_d.rob_pos  = upd_rob_pos_i;
    data_d.lsb_en   = (op == OpL) || (op == OpS);
    data_d.is_store = (op == OpS);
    data_d.rs_en    = known && !data_d.lsb_en;

    unique case (op)
      OpL, OpCali, OpJalr: data_d.imm = {{20{head.inst[31]}}, head.inst[31:20]};
      OpS:                 data_d.imm = {{20{head.inst[31]}}, head.inst[31:25], head.inst[11:7]};
      OpB:                 data_d.imm = {{19{head.inst[31]}}, head.inst[31], head.inst[7],
                                         head.inst[30:25], head.inst[11:8], 1'b0};
      OpLui, OpAuipc:      data_d.imm = {head.inst[31:12], 12'd0};
      OpJal:               data_d.imm = {{11{head.inst[31]}}, head.inst[31], head.inst[19:12],
                                         head.inst[20], head.inst[30:21], 1'b0};
      default:             data_d.imm = '0;
    endcase

    data_d.rs1 = resolve(!(op == OpLui || op == OpAuipc || op == OpJal), head.inst[19:15],
                         reg_rs1_rdy_i, reg_rs1_val_i, reg_rs1_rob_pos_i,
                         rob_rs1_rdy_i, rob_rs1_val_i, cdb_valid_i, cdb_rob_pos_i, cdb_val_i);
    data_d.rs2 = resolve(op == OpCal || op == OpS || op == OpB, head.inst[24:20],
                         reg_rs2_rdy_i, reg_rs2_val_i, reg_rs2_rob_pos_i,
                         rob_rs2_rdy_i, rob_rs2_val_i, cdb_valid_i, cdb_rob_pos_i, cdb_val_i);
  end

  assign full        = (count_q == CntW'(DEPTH));
  assign target_full = data_d.lsb_en ? lsb_full_i : rs_full_i;
  assign active      = rdy_i && !rollback_i;
  // Unknown opcodes are dropped even under back-pressure so they cannot wedge the head.
  assign drop        = active && (count_q != '0) && !known;
  assign fire        = active && (count_q != '0) && known && !rob_full_i && !target_full;
  assign pop         = fire || drop;
  assign push        = active && inst_done_i && !full;

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{pre_j: inst_pre_j_i, pc: inst_pc_i, inst: inst_i};
  end

  // Pointers and occupancy; rollback empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_i) begin
      if (rollback_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PtrW'(pop);
        tail_q  <= tail_q + PtrW'(push);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  // Registered issue bundle; data holds between issues, pulses clear every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q         <= 1'b0;
      illegal_q       <= 1'b0;
      data_q          <= '0;
      data_q.rs1.rdy  <= 1'b1;
      data_q.rs2.rdy  <= 1'b1;
    end else begin
      issue_q   <= fire;
      illegal_q <= drop;
      if (fire) data_q <= data_d;
    end
  end

  assign queue_full_o  = full;
  assign reg_rs1_o     = head.inst[19:15];
  assign reg_rs2_o     = head.inst[24:20];
  assign rob_rs1_pos_o = reg_rs1_rob_pos_i;
  assign rob_rs2_pos_o = reg_rs2_rob_pos_i;
  assign issue_o       = issue_q;
  assign illegal_o     = illegal_q;
  assign rs_en_o       = data_q.rs_en;
  assign lsb_en_o      = data_q.lsb_en;
  assign is_store_o    = data_q.is_store;
  assign rob_pos_o     = data_q.rob_pos;
  assign opcode_o      = data_q.opcode;
  assign funct3_o      = data_q.funct3;
  assign funct7_o      = data_q.funct7;
  assign rd_o          = data_q.rd;
  assign imm_o         = data_q.imm;
  assign pc_o          = data_q.pc;
  assign pre_j_o       = data_q.pre_j;
  assign rs1_rdy_o     = data_q.rs1.rdy;
  assign rs1_val_o     = data_q.rs1.val;
  assign rs1_rob_pos_o = data_q.rs1.pos;
  assign rs2_rdy_o     = data_q.rs2.rdy;
  assign rs2_val_o     = data_q.rs2.val;
  assign rs2_rob_pos_o = data_q.rs2.pos;

endmodule
